// File: rtl/pwr_seq_pkg.sv
// Shared types and widths for the power-sequence Misc block.
package pwr_seq_pkg;

    typedef enum logic [2:0] {
        PWD_IDLE,
        PWD_PRESS_DB,
        PWD_HELD,
        PWD_LONG,
        PWD_RELEASE_DB
    } pwd_state_t;

    localparam int MS_CNT_W = 16;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for an asynchronous active-low input; resets to the idle (high) level.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pulse_width_decoder.sv
// Debounces an active-low pulse and classifies its width (1 ms ticks) as glitch, short or long press.
// state      | meaning
// IDLE       | input high, counters cleared
// PRESS_DB   | input low, waiting DEBOUNCE_MS ticks to accept the press
// HELD       | press accepted, counting width toward LONG_MS
// LONG       | long press declared, width counts on (saturating)
// RELEASE_DB | input high, waiting DEBOUNCE_MS ticks to accept the release; width frozen
module pulse_width_decoder
    import pwr_seq_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_MS  = 16,
    parameter int SHORT_MIN_MS = 50,
    parameter int LONG_MS      = 4000,
    parameter int CNT_W        = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse_in_n,
    input  logic             tick_1ms,
    output logic             level_n,
    output logic             short_evt,
    output logic             long_evt,
    output logic             glitch_evt,
    output logic [CNT_W-1:0] width_ms,
    output logic             width_valid
);

    logic                sync_n;
    pwd_state_t          state_q;
    logic [MS_CNT_W-1:0] db_cnt_q;
    logic [CNT_W-1:0]    width_cnt_q;
    logic                was_long_q;
    logic                level_n_q;
    logic                short_q;
    logic                long_q;
    logic                glitch_q;
    logic                valid_q;
    logic [CNT_W-1:0]    width_ms_q;

    sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (pulse_in_n),
        .q_o (sync_n)
    );

    // An input change always takes priority over a coincident tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= PWD_IDLE;
            db_cnt_q    <= '0;
            width_cnt_q <= '0;
            was_long_q  <= 1'b0;
            level_n_q   <= 1'b1;
            short_q     <= 1'b0;
            long_q      <= 1'b0;
            glitch_q    <= 1'b0;
            valid_q     <= 1'b0;
            width_ms_q  <= '0;
        end else begin
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            glitch_q <= 1'b0;
            valid_q  <= 1'b0;
            case (state_q)
                PWD_IDLE: begin
                    db_cnt_q    <= '0;
                    width_cnt_q <= '0;
                    was_long_q  <= 1'b0;
                    if (!sync_n) state_q <= PWD_PRESS_DB;
                end
                PWD_PRESS_DB: begin
                    if (sync_n) begin
                        state_q <= PWD_IDLE;
                    end else if (tick_1ms) begin
                        if (db_cnt_q + MS_CNT_W'(1) == MS_CNT_W'(DEBOUNCE_MS)) begin
                            state_q     <= PWD_HELD;
                            level_n_q   <= 1'b0;
                            width_cnt_q <= CNT_W'(DEBOUNCE_MS);
                        end else begin
                            db_cnt_q <= db_cnt_q + MS_CNT_W'(1);
                        end
                    end
                end
                PWD_HELD: begin
                    if (sync_n) begin
                        state_q  <= PWD_RELEASE_DB;
                        db_cnt_q <= '0;
                    end else if (tick_1ms) begin
                        width_cnt_q <= width_cnt_q + CNT_W'(1);
                        if (width_cnt_q + CNT_W'(1) == CNT_W'(LONG_MS)) begin
                            state_q    <= PWD_LONG;
                            was_long_q <= 1'b1;
                            long_q     <= 1'b1;
                        end
                    end
                end
                PWD_LONG: begin
                    if (sync_n) begin
                        state_q  <= PWD_RELEASE_DB;
                        db_cnt_q <= '0;
                    end else if (tick_1ms && (width_cnt_q != '1)) begin
                        width_cnt_q <= width_cnt_q + CNT_W'(1);
                    end
                end
                PWD_RELEASE_DB: begin
                    if (!sync_n) begin
                        state_q <= was_long_q ? PWD_LONG : PWD_HELD;
                    end else if (tick_1ms) begin
                        if (db_cnt_q + MS_CNT_W'(1) == MS_CNT_W'(DEBOUNCE_MS)) begin
                            state_q    <= PWD_IDLE;
                            level_n_q  <= 1'b1;
                            width_ms_q <= width_cnt_q;
                            valid_q    <= 1'b1;
                            if (!was_long_q) begin
                                if (width_cnt_q >= CNT_W'(SHORT_MIN_MS)) short_q  <= 1'b1;
                                else                                      glitch_q <= 1'b1;
                            end
                        end else begin
                            db_cnt_q <= db_cnt_q + MS_CNT_W'(1);
                        end
                    end
                end
                default: state_q <= PWD_IDLE;
            endcase
        end
    end

    assign level_n     = level_n_q;
    assign short_evt   = short_q;
    assign long_evt    = long_q;
    assign glitch_evt  = glitch_q;
    assign width_ms    = width_ms_q;
    assign width_valid = valid_q;

endmodule

// File: tb/tb_pulse_width_decoder.sv
// Table-driven press vectors plus hand sequences for bounce, coincident-tick, reset and stalled-tick cases.
module tb_pulse_width_decoder;

    localparam int DB    = 4;
    localparam int SHORT = 10;
    localparam int LONG  = 40;
    localparam int CW    = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          pulse_in_n;
    logic          tick_1ms;
    logic          level_n;
    logic          short_evt;
    logic          long_evt;
    logic          glitch_evt;
    logic [CW-1:0] width_ms;
    logic          width_valid;

    always #5 clk = ~clk;

    pulse_width_decoder #(
        .SYNC_STAGES (2),
        .DEBOUNCE_MS (DB),
        .SHORT_MIN_MS(SHORT),
        .LONG_MS     (LONG),
        .CNT_W       (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pulse_in_n (pulse_in_n),
        .tick_1ms   (tick_1ms),
        .level_n    (level_n),
        .short_evt  (short_evt),
        .long_evt   (long_evt),
        .glitch_evt (glitch_evt),
        .width_ms   (width_ms),
        .width_valid(width_valid)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    endtask

    typedef struct {
        int width;
        int is_short;
        int is_glitch;
    } exp_t;

    exp_t sb_q[$];
    exp_t sb_e;
    int   n_short = 0, n_glitch = 0, n_long = 0, n_valid = 0, n_multi = 0;
    bit   low_seen = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (short_evt)  n_short++;
            if (glitch_evt) n_glitch++;
            if (long_evt)   n_long++;
            if (int'(short_evt) + int'(glitch_evt) + int'(long_evt) > 1) n_multi++;
            if (!level_n) low_seen = 1'b1;
            if (width_valid) begin
                n_valid++;
                check("sb_expected_capture", int'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    sb_e = sb_q.pop_front();
                    check_range("width_ms", int'(width_ms), sb_e.width - 1, sb_e.width + 1);
                    check("short_at_capture", int'(short_evt), sb_e.is_short);
                    check("glitch_at_capture", int'(glitch_evt), sb_e.is_glitch);
                end
            end
        end
    end

    task automatic cyc(input logic t);
        tick_1ms = t;
        @(posedge clk);
        #1;
        tick_1ms = 1'b0;
    endtask

    task automatic ms(input int n);
        repeat (n) begin
            repeat (9) cyc(1'b0);
            cyc(1'b1);
        end
    endtask

    typedef struct {
        int low_ms;
        int exp_short;
        int exp_glitch;
        int exp_long;
        int exp_valid;
        int exp_fell;
        int exp_width;
    } vec_t;

    vec_t vec[11];
    int   s0, g0, l0, v0;

    initial begin
        vec[0]  = '{2,   0, 0, 0, 0, 0, 0};
        vec[1]  = '{3,   0, 0, 0, 0, 0, 0};
        vec[2]  = '{4,   0, 1, 0, 1, 1, 4};
        vec[3]  = '{7,   0, 1, 0, 1, 1, 7};
        vec[4]  = '{9,   0, 1, 0, 1, 1, 9};
        vec[5]  = '{10,  1, 0, 0, 1, 1, 10};
        vec[6]  = '{20,  1, 0, 0, 1, 1, 20};
        vec[7]  = '{39,  1, 0, 0, 1, 1, 39};
        vec[8]  = '{40,  0, 0, 1, 1, 1, 40};
        vec[9]  = '{60,  0, 0, 1, 1, 1, 60};
        vec[10] = '{300, 0, 0, 1, 1, 1, 255};

        rst        = 1'b1;
        pulse_in_n = 1'b1;
        tick_1ms   = 1'b0;
        #23;
        check("reset_level_n", int'(level_n), 1);
        check("reset_width_ms", int'(width_ms), 0);
        check("reset_strobes", int'({short_evt, long_evt, glitch_evt, width_valid}), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) cyc(1'b0);

        for (int i = 0; i < 11; i++) begin
            s0 = n_short; g0 = n_glitch; l0 = n_long; v0 = n_valid;
            low_seen   = 1'b0;
            pulse_in_n = 1'b0;
            if (vec[i].low_ms >= DB) begin
                ms(DB - 1);
                check($sformatf("v%0d_level_before_db", i), int'(level_n), 1);
                ms(1);
                check($sformatf("v%0d_level_after_db", i), int'(level_n), 0);
                ms(vec[i].low_ms - DB);
            end else begin
                ms(vec[i].low_ms);
            end
            if (vec[i].exp_valid != 0)
                sb_q.push_back('{vec[i].exp_width, vec[i].exp_short, vec[i].exp_glitch});
            pulse_in_n = 1'b1;
            ms(DB + 2);
            check($sformatf("v%0d_short_cnt", i), n_short - s0, vec[i].exp_short);
            check($sformatf("v%0d_glitch_cnt", i), n_glitch - g0, vec[i].exp_glitch);
            check($sformatf("v%0d_long_cnt", i), n_long - l0, vec[i].exp_long);
            check($sformatf("v%0d_valid_cnt", i), n_valid - v0, vec[i].exp_valid);
            check($sformatf("v%0d_level_fell", i), int'(low_seen), vec[i].exp_fell);
            check($sformatf("v%0d_level_end", i), int'(level_n), 1);
        end

        // Release bounce: 2 ms high while held, width frozen during it.
        s0 = n_short; g0 = n_glitch; v0 = n_valid;
        pulse_in_n = 1'b0;
        ms(15);
        pulse_in_n = 1'b1;
        ms(2);
        check("relbounce_level_held", int'(level_n), 0);
        pulse_in_n = 1'b0;
        ms(13);
        sb_q.push_back('{28, 1, 0});
        pulse_in_n = 1'b1;
        ms(DB + 2);
        check("relbounce_short_cnt", n_short - s0, 1);
        check("relbounce_glitch_cnt", n_glitch - g0, 0);
        check("relbounce_valid_cnt", n_valid - v0, 1);

        // Release in PRESS_DB lands on the tick that would complete the debounce.
        v0 = n_valid;
        low_seen   = 1'b0;
        pulse_in_n = 1'b0;
        ms(DB - 1);
        repeat (7) cyc(1'b0);
        pulse_in_n = 1'b1;
        cyc(1'b0);
        cyc(1'b0);
        cyc(1'b1);
        ms(DB + 2);
        check("coinc_press_level_fell", int'(low_seen), 0);
        check("coinc_press_valid_cnt", n_valid - v0, 0);

        // Re-press in RELEASE_DB lands on the tick that would complete the release.
        s0 = n_short; v0 = n_valid;
        pulse_in_n = 1'b0;
        ms(20);
        pulse_in_n = 1'b1;
        ms(DB - 1);
        repeat (7) cyc(1'b0);
        pulse_in_n = 1'b0;
        cyc(1'b0);
        cyc(1'b0);
        cyc(1'b1);
        check("coinc_release_level", int'(level_n), 0);
        check("coinc_release_valid_cnt", n_valid - v0, 0);
        ms(10);
        sb_q.push_back('{30, 1, 0});
        pulse_in_n = 1'b1;
        ms(DB + 2);
        check("coinc_release_short_cnt", n_short - s0, 1);
        check("coinc_release_valid_total", n_valid - v0, 1);

        // Reset mid-press, released with the input still low.
        pulse_in_n = 1'b0;
        ms(20);
        check("prereset_width_nonzero", int'(width_ms != '0), 1);
        rst = 1'b1;
        #2;
        check("midrst_level_n", int'(level_n), 1);
        check("midrst_width_ms", int'(width_ms), 0);
        check("midrst_strobes", int'({short_evt, long_evt, glitch_evt, width_valid}), 0);
        repeat (5) cyc(1'b0);
        s0 = n_short; g0 = n_glitch; l0 = n_long; v0 = n_valid;
        rst = 1'b0;
        ms(DB - 1);
        check("postrst_level_before_db", int'(level_n), 1);
        ms(1);
        check("postrst_level_after_db", int'(level_n), 0);
        check("postrst_no_event", (n_short - s0) + (n_glitch - g0) + (n_long - l0) + (n_valid - v0), 0);
        ms(6);
        sb_q.push_back('{10, 1, 0});
        pulse_in_n = 1'b1;
        ms(DB + 2);
        check("postrst_short_cnt", n_short - s0, 1);
        check("postrst_valid_cnt", n_valid - v0, 1);

        // Stalled tick: state and width hold indefinitely.
        s0 = n_short; v0 = n_valid;
        pulse_in_n = 1'b0;
        ms(10);
        repeat (300) cyc(1'b0);
        check("stall_level_n", int'(level_n), 0);
        pulse_in_n = 1'b1;
        repeat (300) cyc(1'b0);
        check("stall_release_level_n", int'(level_n), 0);
        check("stall_valid_cnt", n_valid - v0, 0);
        pulse_in_n = 1'b0;
        ms(5);
        sb_q.push_back('{15, 1, 0});
        pulse_in_n = 1'b1;
        ms(DB + 2);
        check("stall_short_cnt", n_short - s0, 1);
        check("stall_valid_total", n_valid - v0, 1);

        check("sb_drained", sb_q.size(), 0);
        check("strobes_exclusive", n_multi, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
